// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO push arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } ty_FifoArbStates;

  // Requester index width; at least one bit so a single-requester build still has a port.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

  // Beat counter width: holds 0..MAX_BURST-1 with a spare bit.
  function automatic int unsigned beat_cnt_w(input int unsigned max_burst);
    return int'($clog2(max_burst)) + 1;
  endfunction

  // Idle-grant counter width: holds 0..TIMEOUT_CYC-1 with a spare bit.
  function automatic int unsigned idle_cnt_w(input int unsigned timeout_cyc);
    return int'($clog2(timeout_cyc)) + 1;
  endfunction

endpackage

// File: rtl/round_robin_pick.sv
// Combinational round-robin picker: first set request searching upward from lastGrant+1.
module round_robin_pick
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned N    = 4,
  localparam int unsigned ID_W = id_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] lastGrant,
  output logic [ID_W-1:0] winner,
  output logic            anyReq
);

  // Rotate a doubled request vector so bit 0 is the requester after lastGrant, then scan.
  always_comb begin
    logic [2*N-1:0] dbl;
    int unsigned    idx;
    winner = '0;
    anyReq = 1'b0;
    idx    = 0;
    dbl    = {req, req} >> (32'(lastGrant) + 32'd1);
    for (int unsigned i = 0; i < N; i++) begin
      if (!anyReq && dbl[0]) begin
        anyReq = 1'b1;
        idx    = 32'(lastGrant) + 32'd1 + i;
        if (idx >= N) idx = idx - N;
        winner = ID_W'(idx);
      end
      dbl = dbl >> 1;
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port between NUM_REQ burst requesters.
// Optional idle-grant timeout enabled by defining FIFO_ARB_TIMEOUT_EN.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MAX_BURST   = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                           ck,
  input  logic                           srstN,
  input  logic [NUM_REQ-1:0]             reqValid,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] reqData,
  input  logic [NUM_REQ-1:0]             reqLast,
  output logic [NUM_REQ-1:0]             reqReady,
  output logic                           fifoPush,
  output logic [DATA_W-1:0]              fifoData,
  input  logic                           fifoFull,
  output logic [id_w(NUM_REQ)-1:0]       grantId,
  output logic                           busy
);

  localparam int unsigned ID_W   = id_w(NUM_REQ);
  localparam int unsigned BEAT_W = beat_cnt_w(MAX_BURST);

  // Reject configurations outside the supported ranges at elaboration.
  if (NUM_REQ < 1 || NUM_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 256 || TIMEOUT_CYC < 1)
  begin : g_bad_param
    $error("fifo_push_arbiter: parameter out of range");
  end

  ty_FifoArbStates   state;
  logic [BEAT_W-1:0] beat_cnt;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   winner;
  logic              any_req;

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int unsigned IDLE_W = idle_cnt_w(TIMEOUT_CYC);
  logic [IDLE_W-1:0] idle_cnt;
`endif

  round_robin_pick #(.N(NUM_REQ)) u_pick (
    .req      (reqValid),
    .lastGrant(last_grant),
    .winner   (winner),
    .anyReq   (any_req)
  );

  assign busy = (state == ST_BURST);

  // Zero-latency forwarding of the granted requester, throttled by the FIFO full flag.
  always_comb begin
    reqReady = '0;
    fifoPush = 1'b0;
    fifoData = '0;
    if (state == ST_BURST) begin
      reqReady[grantId] = !fifoFull;
      fifoPush          = reqValid[grantId] && !fifoFull;
      if (fifoPush) fifoData = reqData[grantId];
    end
  end

  // Grant FSM: one arbitration cycle in idle, then hold the grant until last, beat limit or timeout.
  always_ff @(posedge ck) begin
    if (!srstN) begin
      state      <= ST_IDLE;
      grantId    <= '0;
      beat_cnt   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
`ifdef FIFO_ARB_TIMEOUT_EN
      idle_cnt   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state    <= ST_BURST;
            grantId  <= winner;
            beat_cnt <= '0;
`ifdef FIFO_ARB_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
        end
        ST_BURST: begin
          if (fifoPush) begin
`ifdef FIFO_ARB_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (reqLast[grantId] || beat_cnt == BEAT_W'(MAX_BURST - 1)) begin
              state      <= ST_IDLE;
              last_grant <= grantId;
              beat_cnt   <= '0;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
`ifdef FIFO_ARB_TIMEOUT_EN
          else if (!reqValid[grantId] && !fifoFull) begin
            if (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
              state      <= ST_IDLE;
              last_grant <= grantId;
              idle_cnt   <= '0;
            end else begin
              idle_cnt <= idle_cnt + IDLE_W'(1);
            end
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter (timeout scenario runs when FIFO_ARB_TIMEOUT_EN is defined).
module tb_fifo_push_arbiter;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned MAX_BURST   = 8;
  localparam int unsigned TIMEOUT_CYC = 16;

  logic                           ck = 1'b0;
  logic                           srstN;
  logic [NUM_REQ-1:0]             reqValid;
  logic [NUM_REQ-1:0][DATA_W-1:0] reqData;
  logic [NUM_REQ-1:0]             reqLast;
  logic [NUM_REQ-1:0]             reqReady;
  logic                           fifoPush;
  logic [DATA_W-1:0]              fifoData;
  logic                           fifoFull;
  logic [1:0]                     grantId;
  logic                           busy;

  int n_checks = 0;
  int n_errors = 0;
  bit prev_push;
  int prev_id;

  fifo_push_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .ck(ck), .srstN(srstN), .reqValid(reqValid), .reqData(reqData), .reqLast(reqLast),
    .reqReady(reqReady), .fifoPush(fifoPush), .fifoData(fifoData), .fifoFull(fifoFull),
    .grantId(grantId), .busy(busy)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  // Compare every output for one cycle; ready follows the bench's own fifoFull drive.
  task automatic chk_cycle(input string tag, input int c, input bit eb, input int eid,
                           input bit ep, input logic [7:0] ed);
    logic [3:0] er;
    er = (eb && !fifoFull) ? 4'(4'b0001 << eid) : 4'b0000;
    chk($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(eb));
    chk($sformatf("%s c%0d grant", tag, c), 32'(grantId), 32'(eid));
    chk($sformatf("%s c%0d push", tag, c), 32'(fifoPush), 32'(ep));
    chk($sformatf("%s c%0d ready", tag, c), 32'(reqReady), 32'(er));
    chk($sformatf("%s c%0d data", tag, c), 32'(fifoData), ep ? 32'(ed) : 32'd0);
    prev_push = ep;
    prev_id   = eid;
  endtask

  initial begin
    int n, n1, n3;
    bit eb, ep;
    int eid;
    logic [7:0] ed;

    // Reset with every requester valid and single-beat bursts.
    srstN    = 1'b0;
    fifoFull = 1'b0;
    reqValid = 4'b1111;
    reqLast  = 4'b1111;
    for (int i = 0; i < 4; i++) reqData[i] = 8'(8'hA0 + i);
    tick();
    tick();
    #1;
    chk_cycle("rst", 0, 1'b0, 0, 1'b0, 8'h00);
    srstN = 1'b1;

    // Single-beat rotation 0,1,2,3,0 with an idle cycle between grants.
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      chk_cycle("rr_burst", k, 1'b1, k % 4, 1'b1, 8'(8'hA0 + (k % 4)));
      tick(); #1;
      chk_cycle("rr_idle", k, 1'b0, k % 4, 1'b0, 8'h00);
    end

    // Requester 2 alone, 20 beats without last: groups of 8, 8, 4.
    n = 0;
    reqValid   = 4'b0100;
    reqLast    = 4'b0000;
    reqData[2] = 8'h10;
    prev_push  = 1'b0;
    for (int c = 0; c <= 22; c++) begin
      tick();
      if (prev_push) n++;
      reqData[2] = 8'(8'h10 + n);
      if (n == 20) reqValid = 4'b0000;
      #1;
      eb = (c != 8) && (c != 17);
      ep = eb && (c < 22);
      chk_cycle("long", c, eb, 2, ep, 8'(8'h10 + n));
    end

    // Stalled grant can only be cleared by reset in the default build.
    srstN = 1'b0;
    tick(); #1;
    chk_cycle("rst2", 0, 1'b0, 0, 1'b0, 8'h00);
    srstN = 1'b1;

    // Requester 0 burst with fifoFull high for 5 cycles after 3 beats.
    n = 0;
    reqValid   = 4'b0001;
    reqData[0] = 8'h40;
    prev_push  = 1'b0;
    for (int c = 0; c <= 13; c++) begin
      tick();
      if (prev_push) n++;
      reqData[0] = 8'(8'h40 + n);
      fifoFull   = (c >= 3) && (c <= 7);
      if (n == 8) reqValid = 4'b0000;
      #1;
      eb = (c != 13);
      ep = eb && !fifoFull;
      chk_cycle("full", c, eb, 0, ep, 8'(8'h40 + n));
    end
    chk("full beats", 32'(n), 32'd8);

    // Requesters 1 and 3 compete; reset lands mid-burst at beatCnt 5.
    n1 = 0;
    n3 = 0;
    prev_push = 1'b0;
    reqValid  = 4'b1010;
    reqLast   = 4'b0000;
    reqData[1] = 8'h50;
    reqData[3] = 8'h70;
    for (int c = 0; c <= 14; c++) begin
      tick();
      if (prev_push && prev_id == 1) n1++;
      if (prev_push && prev_id == 3) n3++;
      reqData[1]  = 8'(8'h50 + n1);
      reqData[3]  = 8'(8'h70 + n3);
      reqLast[1]  = (n1 == 2);
      reqLast[3]  = (n3 == 1);
      reqValid[3] = (n3 < 2);
      srstN       = (c != 12);
      #1;
      eb  = !(c == 3 || c == 6 || c == 13);
      eid = (c <= 3) ? 1 : (c <= 6) ? 3 : (c == 13) ? 0 : 1;
      ed  = (eid == 3) ? 8'(8'h70 + n3) : 8'(8'h50 + n1);
      chk_cycle("pair", c, eb, eid, eb, ed);
    end

`ifdef FIFO_ARB_TIMEOUT_EN
    // Requester 0 stalls after 2 beats; timeout hands the grant to requester 1.
    srstN = 1'b0;
    tick(); #1;
    srstN = 1'b1;
    n = 0;
    prev_push  = 1'b0;
    reqValid   = 4'b0001;
    reqLast    = 4'b0000;
    reqData[0] = 8'h60;
    reqData[1] = 8'h61;
    for (int c = 0; c <= 19; c++) begin
      tick();
      if (prev_push) n++;
      if (n == 2) reqValid = 4'b0010;
      #1;
      eb = (c != 18);
      ep = (c < 2) || (c == 19);
      ed = (c == 19) ? 8'h61 : 8'h60;
      chk_cycle("tmo", c, eb, (c == 19) ? 1 : 0, ep, ed);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
